// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit encoding, head-flit field layout and the
// network-interface transmit states.
package noc_pkg;

    typedef enum logic [1:0] {
        FT_BODY = 2'b00,
        FT_HEAD = 2'b01,
        FT_TAIL = 2'b10
    } flit_type_e;

    localparam int unsigned NOC_DATA_W = 32;

    typedef struct packed {
        flit_type_e            ftype;
        logic [NOC_DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_HEAD,
        TX_BODY
    } tx_state_e;

    // Head-flit field LSB positions, packed MSB-first: dst_x, dst_y, src_x, src_y, len.
    function automatic int unsigned hd_dst_x_lsb(input int unsigned data_w, input int unsigned coord_w);
        return data_w - coord_w;
    endfunction

    function automatic int unsigned hd_dst_y_lsb(input int unsigned data_w, input int unsigned coord_w);
        return data_w - 2 * coord_w;
    endfunction

    function automatic int unsigned hd_src_x_lsb(input int unsigned data_w, input int unsigned coord_w);
        return data_w - 3 * coord_w;
    endfunction

    function automatic int unsigned hd_src_y_lsb(input int unsigned data_w, input int unsigned coord_w);
        return data_w - 4 * coord_w;
    endfunction

    function automatic int unsigned hd_len_lsb(input int unsigned data_w, input int unsigned coord_w,
                                               input int unsigned len_w);
        return data_w - 4 * coord_w - len_w;
    endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter mirroring the free slots of the downstream input buffer;
// returns above the buffer depth saturate.
module noc_credit_counter
    import noc_pkg::*;
#(
    parameter  int unsigned CREDITS = 4,
    localparam int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             consume,
    input  logic             credit_i,
    output logic [CNT_W-1:0] cnt,
    output logic             avail
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             take;

    assign take = consume && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (take && !credit_i) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (!take && credit_i && (cnt_q != CNT_W'(CREDITS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= CNT_W'(CREDITS);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt   = cnt_q;
    assign avail = (cnt_q != '0);

endmodule

// File: rtl/noc_ni_tx.sv
// Network-interface transmit stage: turns a descriptor plus payload stream
// into a credit-gated HEAD/BODY/TAIL packet for the router's local port.
module noc_ni_tx
    import noc_pkg::*;
#(
    parameter  int unsigned DATA_W  = 32,
    parameter  int unsigned COORD_W = 2,
    parameter  int unsigned MAX_LEN = 8,
    parameter  int unsigned CREDITS = 4,
    parameter  int unsigned SRC_X   = 0,
    parameter  int unsigned SRC_Y   = 0,
    localparam int unsigned FLIT_W  = DATA_W + 2,
    localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1),
    localparam int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               msg_valid,
    output logic               msg_ready,
    input  logic [COORD_W-1:0] msg_dst_x,
    input  logic [COORD_W-1:0] msg_dst_y,
    input  logic [LEN_W-1:0]   msg_len,
    input  logic               pld_valid,
    output logic               pld_ready,
    input  logic [DATA_W-1:0]  pld_data,
    output logic               flit_valid,
    output logic [FLIT_W-1:0]  flit_o,
    input  logic               credit_i,
    output logic [CNT_W-1:0]   credit_cnt,
    output logic               err_o
);

    localparam int unsigned DX_LSB  = hd_dst_x_lsb(DATA_W, COORD_W);
    localparam int unsigned DY_LSB  = hd_dst_y_lsb(DATA_W, COORD_W);
    localparam int unsigned SX_LSB  = hd_src_x_lsb(DATA_W, COORD_W);
    localparam int unsigned SY_LSB  = hd_src_y_lsb(DATA_W, COORD_W);
    localparam int unsigned LEN_LSB = hd_len_lsb(DATA_W, COORD_W, LEN_W);

    tx_state_e          state_q;
    logic [COORD_W-1:0] dst_x_q;
    logic [COORD_W-1:0] dst_y_q;
    logic [LEN_W-1:0]   rem_q;
    logic [FLIT_W-1:0]  flit_q;
    logic               flit_valid_q;
    logic               err_q;

    logic               avail;
    logic               msg_hs;
    logic               pld_hs;
    logic               send;
    logic               len_ok;
    logic [DATA_W-1:0]  head_data;

    assign msg_ready = (state_q == TX_IDLE);
    assign pld_ready = (state_q == TX_BODY) && avail;
    assign msg_hs    = msg_valid && msg_ready;
    assign pld_hs    = pld_valid && pld_ready;
    assign send      = ((state_q == TX_HEAD) && avail) || pld_hs;
    assign len_ok    = (msg_len != '0) && (msg_len <= LEN_W'(MAX_LEN));

    // rem_q still equals the latched length while in HEAD, so it doubles as the len field.
    always_comb begin
        head_data                       = '0;
        head_data[DX_LSB +: COORD_W]    = dst_x_q;
        head_data[DY_LSB +: COORD_W]    = dst_y_q;
        head_data[SX_LSB +: COORD_W]    = COORD_W'(SRC_X);
        head_data[SY_LSB +: COORD_W]    = COORD_W'(SRC_Y);
        head_data[LEN_LSB +: LEN_W]     = rem_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= TX_IDLE;
            dst_x_q      <= '0;
            dst_y_q      <= '0;
            rem_q        <= '0;
            flit_q       <= '0;
            flit_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            flit_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (msg_hs) begin
                        if (len_ok) begin
                            dst_x_q <= msg_dst_x;
                            dst_y_q <= msg_dst_y;
                            rem_q   <= msg_len;
                            state_q <= TX_HEAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                TX_HEAD: begin
                    if (avail) begin
                        flit_q       <= {FT_HEAD, head_data};
                        flit_valid_q <= 1'b1;
                        state_q      <= TX_BODY;
                    end
                end
                TX_BODY: begin
                    if (pld_hs) begin
                        flit_valid_q <= 1'b1;
                        rem_q        <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) begin
                            flit_q  <= {FT_TAIL, pld_data};
                            state_q <= TX_IDLE;
                        end else begin
                            flit_q <= {FT_BODY, pld_data};
                        end
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    noc_credit_counter #(
        .CREDITS(CREDITS)
    ) u_credit (
        .clk     (clk),
        .rst_n   (rst_n),
        .consume (send),
        .credit_i(credit_i),
        .cnt     (credit_cnt),
        .avail   (avail)
    );

    assign flit_valid = flit_valid_q;
    assign flit_o     = flit_q;
    assign err_o      = err_q;

endmodule
